// File: rtl/reg_dump_scanner.sv
// Purpose : walks the CPU debug register port (reg_sel/reg_data) and streams a framed byte dump.
// Latency : SOF byte the cycle after start; then SETTLE+5 cycles per register with out_ready held high.
// Backpr. : valid/ready; out_valid/out_data hold until accepted, out_valid never looks at out_ready.
//
// Ports:
//   clk, rstn           - sole clock, synchronous active-low reset
//   start               - one-cycle dump request, ignored unless idle
//   reg_sel / reg_data  - debug register index out, register value in (combinational from reg_sel)
//   out_valid/out_ready/out_data - byte stream: A5, then {idx, w[31:24], w[23:16], w[15:8], w[7:0]} per register
//   busy, done          - dump in progress; one-cycle pulse after the final byte is accepted
//
// Optional feature: define REG_DUMP_CKSUM_EN to append an XOR checksum byte over every byte after SOF.
module reg_dump_scanner #(
    parameter int LAST_REG = 31,
    parameter int SETTLE   = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] LP_LAST      = 5'(LAST_REG);
    localparam logic [3:0] LP_SET_FINAL = 4'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOF,
        S_SETTLE,
        S_SEND,
`ifdef REG_DUMP_CKSUM_EN
        S_CKSUM,
`endif
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_nxt;
    logic [4:0]  r_sel;
    logic [3:0]  r_cnt;      // cycles elapsed since reg_sel last changed
    logic        r_cap;      // word for the current reg_sel already latched (only possible early in SOF)
    logic [2:0]  r_bcnt;     // 0 = index byte, 1..4 = data bytes MSB first
    logic [31:0] r_shift;
    logic        w_cap;
    logic        w_acc;
    logic        w_last_byte;
`ifdef REG_DUMP_CKSUM_EN
    logic [7:0]  r_ck;
`endif

    assign reg_sel     = r_sel;
    assign w_acc       = out_valid && out_ready;
    assign w_last_byte = (r_bcnt == 3'd4);

    always_comb begin
        w_nxt     = r_state;
        out_valid = 1'b0;
        out_data  = 8'h00;
        busy      = 1'b1;
        done      = 1'b0;
        w_cap     = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_nxt = S_SOF;
            end
            S_SOF: begin
                out_valid = 1'b1;
                out_data  = 8'hA5;
                // register 0 settles underneath the SOF byte
                w_cap = !r_cap && (r_cnt == LP_SET_FINAL);
                if (out_ready) w_nxt = (r_cap || w_cap) ? S_SEND : S_SETTLE;
            end
            S_SETTLE: begin
                w_cap = (r_cnt == LP_SET_FINAL);
                if (w_cap) w_nxt = S_SEND;
            end
            S_SEND: begin
                out_valid = 1'b1;
                out_data  = (r_bcnt == 3'd0) ? {3'b000, r_sel} : r_shift[31:24];
                if (out_ready && w_last_byte) begin
                    if (r_sel == LP_LAST) begin
`ifdef REG_DUMP_CKSUM_EN
                        w_nxt = S_CKSUM;
`else
                        w_nxt = S_DONE;
`endif
                    end else begin
                        w_nxt = S_SETTLE;
                    end
                end
            end
`ifdef REG_DUMP_CKSUM_EN
            S_CKSUM: begin
                out_valid = 1'b1;
                out_data  = r_ck;
                if (out_ready) w_nxt = S_DONE;
            end
`endif
            S_DONE: begin
                busy  = 1'b0;
                done  = 1'b1;
                w_nxt = S_IDLE;
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_sel   <= 5'd0;
            r_cnt   <= 4'd0;
            r_cap   <= 1'b0;
            r_bcnt  <= 3'd0;
            r_shift <= 32'd0;
`ifdef REG_DUMP_CKSUM_EN
            r_ck    <= 8'h00;
`endif
        end else begin
            r_state <= w_nxt;
            if (r_state == S_IDLE && start) begin
                r_sel <= 5'd0;
                r_cnt <= 4'd0;
                r_cap <= 1'b0;
`ifdef REG_DUMP_CKSUM_EN
                r_ck  <= 8'h00;
`endif
            end
            if ((r_state == S_SOF || r_state == S_SETTLE) && !r_cap) begin
                r_cnt <= r_cnt + 4'd1;
            end
            if (w_cap) begin
                r_shift <= reg_data;
                r_bcnt  <= 3'd0;
                r_cap   <= 1'b1;
            end
            if (r_state == S_SEND && w_acc) begin
                r_bcnt <= r_bcnt + 3'd1;
                // the index byte does not consume the word; data bytes shift it up
                if (r_bcnt != 3'd0) r_shift <= {r_shift[23:0], 8'h00};
`ifdef REG_DUMP_CKSUM_EN
                r_ck <= r_ck ^ out_data;
`endif
                if (w_last_byte && r_sel != LP_LAST) begin
                    r_sel <= r_sel + 5'd1;
                    r_cnt <= 4'd0;
                    r_cap <= 1'b0;
                end
            end
        end
    end

endmodule
